// File: rtl/mul_arbiter.sv
// -----------------------------------------------------------------------------
// mul_arbiter
//
// Purpose:
//   Shares a single WIDTH x WIDTH signed fixed-point multiplier among NUM_REQ
//   requesters. Each cycle at most one requester is granted; its operand pair is
//   multiplied and the truncated fixed-point product is registered into a
//   one-entry output stage together with the requester index. The output stage
//   uses a valid/ready handshake and can be refilled in the same cycle it
//   drains, so sustained throughput is one result per cycle.
//
//   Product format: the full signed 2*WIDTH product is formed and bits
//   [WIDTH+FRAC_WIDTH-1:FRAC_WIDTH] are returned (truncation, wraps on overflow).
//
// Configuration macro:
//   MUL_ARBITER_ROUND_ROBIN_EN
//     defined   : round-robin arbitration. Search starts at a priority pointer
//                 p and wraps NUM_REQ-1 -> 0; after every transfer to g the
//                 pointer becomes (g+1) mod NUM_REQ.
//     undefined : fixed priority, lowest index wins; there is no pointer state.
//
// Parameters:
//   NUM_REQ    number of requesters (2..16)
//   WIDTH      signed operand / result width
//   FRAC_WIDTH fractional bits (< WIDTH)
//
// Ports:
//   clk        clock, all state changes on rising edge
//   rst        synchronous active-high reset
//   req_valid  [NUM_REQ]         per-requester operand pair valid
//   req_a      [NUM_REQ*WIDTH]   operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      [NUM_REQ*WIDTH]   operand B, same packing
//   req_ready  [NUM_REQ]         one-hot-or-zero grant (transfer = valid&ready)
//   rsp_valid                    result valid
//   rsp_ready                    downstream accepts result
//   rsp_data   [WIDTH]           fixed-point product
//   rsp_id     [ID_W]            index of requester owning rsp_data
// -----------------------------------------------------------------------------
module mul_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 32,
  parameter int FRAC_WIDTH = 16,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id
);

  // ---------------------------------------------------------------------------
  // Operand unpacking
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] op_a [NUM_REQ];
  logic [WIDTH-1:0] op_b [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign op_a[gi] = req_a[gi*WIDTH +: WIDTH];
    assign op_b[gi] = req_b[gi*WIDTH +: WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Output register state
  // ---------------------------------------------------------------------------
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [ID_W-1:0]  rsp_id_q;

  // Output stage is empty, or its content leaves this cycle.
  logic can_issue;
  assign can_issue = !rsp_valid_q || rsp_ready;

  // ---------------------------------------------------------------------------
  // Search base: the priority pointer in round-robin mode, constant 0 otherwise
  // ---------------------------------------------------------------------------
  logic [ID_W-1:0] search_base;

`ifdef MUL_ARBITER_ROUND_ROBIN_EN
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;
  assign search_base = ptr_q;
`else
  assign search_base = '0;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration
  //   Rotate the valid vector so that bit 0 corresponds to the search base,
  //   find the lowest set bit (offset), then map back to an absolute index.
  //   Only req_valid, the pointer and the output handshake feed this path;
  //   operand data never influences the grant.
  // ---------------------------------------------------------------------------
  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [NUM_REQ-1:0]   rot_valid;
  logic [ID_W-1:0]      offset;
  logic                 any_valid;
  logic [ID_W:0]        grant_sum;
  logic [ID_W-1:0]      grant_idx;
  logic                 issue;

  assign valid_dbl = {req_valid, req_valid};
  assign rot_valid = NUM_REQ'(valid_dbl >> search_base);
  assign any_valid = |rot_valid;

  always_comb begin
    offset = '0;
    // Descending scan: the last hit written is the lowest set offset.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        offset = ID_W'(k);
      end
    end
  end

  // base + offset is at most 2*NUM_REQ-2, so one conditional subtract wraps it.
  always_comb begin
    grant_sum = {1'b0, search_base} + {1'b0, offset};
    if (grant_sum >= (ID_W+1)'(NUM_REQ)) begin
      grant_sum = grant_sum - (ID_W+1)'(NUM_REQ);
    end
    grant_idx = grant_sum[ID_W-1:0];
  end

  // Reset forces all grants low in the same cycle.
  assign issue = any_valid && can_issue && !rst;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = issue && (grant_idx == ID_W'(gi));
  end

  // ---------------------------------------------------------------------------
  // Shared multiplier
  //   product_full is declared 2*WIDTH wide so the operands are sign-extended
  //   before the multiply; the result keeps the window above FRAC_WIDTH.
  // ---------------------------------------------------------------------------
  logic signed [WIDTH-1:0]   mul_a;
  logic signed [WIDTH-1:0]   mul_b;
  logic signed [2*WIDTH-1:0] product_full;
  logic        [WIDTH-1:0]   mul_res;

  assign mul_a        = $signed(op_a[grant_idx]);
  assign mul_b        = $signed(op_b[grant_idx]);
  assign product_full = mul_a * mul_b;
  assign mul_res      = WIDTH'(product_full >>> FRAC_WIDTH);

  // ---------------------------------------------------------------------------
  // Next pointer: one past the granted requester, wrapping at NUM_REQ
  // ---------------------------------------------------------------------------
`ifdef MUL_ARBITER_ROUND_ROBIN_EN
  logic [ID_W:0] ptr_inc;

  always_comb begin
    ptr_inc = {1'b0, grant_idx} + (ID_W+1)'(1);
    if (ptr_inc >= (ID_W+1)'(NUM_REQ)) begin
      ptr_inc = '0;
    end
    ptr_d = ptr_inc[ID_W-1:0];
  end
`endif

  // ---------------------------------------------------------------------------
  // Output register and pointer
  //   A new issue always wins over draining, which gives back-to-back results
  //   when the downstream accepts every cycle. Without an issue the stage only
  //   empties on acceptance, so a stalled result stays frozen.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
`ifdef MUL_ARBITER_ROUND_ROBIN_EN
      ptr_q       <= '0;
`endif
    end else begin
      if (issue) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= mul_res;
        rsp_id_q    <= grant_idx;
`ifdef MUL_ARBITER_ROUND_ROBIN_EN
        ptr_q       <= ptr_d;
`endif
      end else if (rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mul_arbiter
//   Directed and randomized bench for mul_arbiter (NUM_REQ=4, WIDTH=32,
//   FRAC_WIDTH=16). The reference keeps a queue of issued results and a
//   priority pointer; grants are recomputed from the arbitration rule and
//   products with 64-bit integer arithmetic. Follows the same
//   MUL_ARBITER_ROUND_ROBIN_EN setting as the design.
// -----------------------------------------------------------------------------
module tb_mul_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int F  = 16;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [IW-1:0]  rsp_id;

  always #5 clk = ~clk;

  mul_arbiter #(.NUM_REQ(N), .WIDTH(W), .FRAC_WIDTH(F)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] data;
    int           id;
  } rsp_t;

  rsp_t exp_q[$];
  int   m_ptr = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Fixed-point product: signed multiply, drop FRAC bits, keep W bits.
  function automatic logic [W-1:0] fx_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return W'(p >>> F);
  endfunction

  // First valid requester at or after base, wrapping.
  function automatic int pick(input logic [N-1:0] v, input int base);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (base + k) % N;
      if (v[idx[IW-1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = $urandom;
      req_b[i*W +: W] = $urandom;
    end
  endtask

  // Called at posedge+1: checks outputs, advances one clock, updates the model.
  task automatic cycle(input string tag);
    int           g;
    logic [N-1:0] eg;
    logic         rdy_s;
    logic         rst_s;
    logic [W-1:0] a_s;
    logic [W-1:0] b_s;
    #2;
    g = -1;
    if (!rst && (exp_q.size() == 0 || rsp_ready)) g = pick(req_valid, m_ptr);
    eg = '0;
    if (g >= 0) eg[g[IW-1:0]] = 1'b1;
    check({tag, ".req_ready"}, 64'(req_ready), 64'(eg));
    check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check({tag, ".rsp_data"}, 64'(rsp_data), 64'(exp_q[0].data));
      check({tag, ".rsp_id"}, 64'(rsp_id), 64'(exp_q[0].id));
    end
    rdy_s = rsp_ready;
    rst_s = rst;
    a_s   = '0;
    b_s   = '0;
    if (g >= 0) begin
      a_s = req_a[g*W +: W];
      b_s = req_b[g*W +: W];
    end
    @(posedge clk);
    #1;
    if (rst_s) begin
      exp_q.delete();
      m_ptr = 0;
    end else begin
      if (exp_q.size() != 0 && rdy_s) begin
        $display("rsp accepted id=%0d data=%08h", exp_q[0].id, exp_q[0].data);
        void'(exp_q.pop_front());
      end
      if (g >= 0) begin
        exp_q.push_back('{data: fx_mul(a_s, b_s), id: g});
`ifdef MUL_ARBITER_ROUND_ROBIN_EN
        m_ptr = (g + 1) % N;
`endif
      end
    end
  endtask

  initial begin
    logic [N-1:0] eg_c;
    logic [W-1:0] held_data;
    logic [IW-1:0] held_id;

    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset: grants suppressed, outputs cleared
    cycle("reset");
    check("reset.rsp_data", 64'(rsp_data), 64'h0);
    check("reset.rsp_id", 64'(rsp_id), 64'h0);
    rst = 1'b0;
    req_valid = '0;
    cycle("idle");

    // 1.5 * 2.0 = 3.0 from requester 0
    req_valid = 4'b0001;
    req_a[0*W +: W] = 32'h00018000;
    req_b[0*W +: W] = 32'h00020000;
    cycle("mul0");
    check("mul0.valid", 64'(rsp_valid), 64'h1);
    check("mul0.data", 64'(rsp_data), 64'h00030000);
    check("mul0.id", 64'(rsp_id), 64'h0);
    req_valid = '0;
    cycle("mul0.drain");

    // -1.0 * 0.5 = -0.5 from requester 2
    req_valid = 4'b0100;
    req_a[2*W +: W] = 32'hFFFF0000;
    req_b[2*W +: W] = 32'h00008000;
    cycle("mul2");
    check("mul2.data", 64'(rsp_data), 64'hFFFF8000);
    check("mul2.id", 64'(rsp_id), 64'h2);
    req_valid = '0;
    cycle("mul2.drain");

    // Pointer now at 3 (round-robin): only req 1 valid -> wrap to 1
    req_valid = 4'b0010;
    #1;
    check("wrap.grant", 64'(req_ready), 64'h2);
    cycle("wrap");
    req_valid = 4'b1110;
    #1;
`ifdef MUL_ARBITER_ROUND_ROBIN_EN
    eg_c = 4'b0100;
`else
    eg_c = 4'b0010;
`endif
    check("wrap.next_grant", 64'(req_ready), 64'(eg_c));
    cycle("wrap.next");
    req_valid = '0;
    cycle("wrap.drain");

    // Reset while a result is held
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    cycle("hold.pre");
    check("hold.pre.valid", 64'(rsp_valid), 64'h1);
    req_valid = '0;
    rst = 1'b1;
    cycle("midrst");
    rst = 1'b0;
    rsp_ready = 1'b1;
    check("midrst.valid", 64'(rsp_valid), 64'h0);
    check("midrst.data", 64'(rsp_data), 64'h0);
    check("midrst.id", 64'(rsp_id), 64'h0);
    cycle("midrst.idle");

    // All requesters valid continuously
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      #1;
`ifdef MUL_ARBITER_ROUND_ROBIN_EN
      eg_c = 4'b0001 << (i % N);
`else
      eg_c = 4'b0001;
`endif
      check("stream.grant", 64'(req_ready), 64'(eg_c));
      cycle("stream");
`ifdef MUL_ARBITER_ROUND_ROBIN_EN
      check("stream.id", 64'(rsp_id), 64'(i % N));
`else
      check("stream.id", 64'(rsp_id), 64'h0);
`endif
    end

    // Backpressure for 3 cycles, then release
    rsp_ready = 1'b0;
    held_data = rsp_data;
    held_id   = rsp_id;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      cycle("stall");
      check("stall.data", 64'(rsp_data), 64'(held_data));
      check("stall.id", 64'(rsp_id), 64'(held_id));
      check("stall.valid", 64'(rsp_valid), 64'h1);
    end
    rsp_ready = 1'b1;
    #1;
    check("release.grant", 64'(req_ready), 64'h1);
    cycle("release");

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(63) == 0);
      req_valid = N'($urandom);
      rsp_ready = ($urandom_range(3) != 0);
      rand_ops();
      cycle("rand");
    end

    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    cycle("final");
    cycle("final.idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter WIDTH, default 32, signed fixed-point operand/result width.
REQ-003 SHALL have parameter FRAC_WIDTH, default 16, fractional bits (less than WIDTH).
REQ-004 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have port req_valid, input, NUM_REQ, per-requester operand-pair valid.
REQ-007 SHALL have port req_a, input, NUM_REQ*WIDTH, operand A of requester i at slice [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_b, input, NUM_REQ*WIDTH, operand B, same packing as req_a.
REQ-009 SHALL have port req_ready, output, NUM_REQ, one-hot-or-zero grant; a transfer occurs on req_valid[i] & req_ready[i].
REQ-010 SHALL have port rsp_valid, output, 1, result valid.
REQ-011 SHALL have port rsp_ready, input, 1, downstream accepts result.
REQ-012 SHALL have port rsp_data, output, WIDTH, signed fixed-point product.
REQ-013 SHALL have port rsp_id, output, $clog2(NUM_REQ) (min 1), index of the requester owning rsp_data.

Function
REQ-014 SHALL share one WIDTH x WIDTH signed multiplier among all requesters, at most one issue per cycle.
REQ-015 SHALL compute a signed 2*WIDTH product and return bits [WIDTH+FRAC_WIDTH-1:FRAC_WIDTH] (truncation, wrap on overflow, no saturation).
REQ-016 SHALL define can_issue = !rsp_valid | rsp_ready (the output register is empty or drains this cycle).
REQ-017 SHALL assert req_ready[g] for exactly one requester g with req_valid[g]=1 when can_issue=1 and any req_valid is set; otherwise all req_ready=0.
REQ-018 SHALL compute req_ready combinationally from req_valid, the priority pointer, rsp_valid and rsp_ready only; never from req_a/req_b.
REQ-019 SHALL, on a transfer in cycle t, present rsp_valid=1 with rsp_data and rsp_id=g in cycle t+1 (1-cycle latency).
REQ-020 SHALL hold rsp_valid, rsp_data, rsp_id stable while rsp_valid=1 and rsp_ready=0.
REQ-021 SHALL clear rsp_valid after a cycle with rsp_valid & rsp_ready and no new transfer.
REQ-022 SHALL, when rsp_valid & rsp_ready and a transfer occur in the same cycle, load the new result (sustained throughput 1 result/cycle).
REQ-023 SHALL not change the priority pointer in cycles without a transfer.
REQ-024 SHALL deliver results in issue order; no result is dropped or duplicated.

Reset
REQ-025 SHALL, while rst=1, drive req_ready=0 and, on the next edge, set rsp_valid=0, rsp_data=0, rsp_id=0, priority pointer=0.
REQ-026 SHALL discard any in-flight or held result when rst is asserted mid-operation; no rsp_valid after reset until a new transfer.

Configuration
REQ-027 SHALL support macro MUL_ARBITER_ROUND_ROBIN_EN.
REQ-028 SHALL, with MUL_ARBITER_ROUND_ROBIN_EN defined, grant the first valid requester searching from pointer p upward with wrap NUM_REQ-1 -> 0, and set p = (g+1) mod NUM_REQ after each transfer.
REQ-029 SHALL, without MUL_ARBITER_ROUND_ROBIN_EN, grant the lowest-index valid requester (fixed priority); the pointer is unused and held at 0.

Verification (NUM_REQ=4, WIDTH=32, FRAC_WIDTH=16, round-robin enabled unless noted)
REQ-030 SHALL cover: req 0 sends a=0x00018000, b=0x00020000, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=0x00030000, rsp_id=0.
REQ-031 SHALL cover: req 2 sends a=0xFFFF0000, b=0x00008000 -> rsp_data=0xFFFF8000, rsp_id=2.
REQ-032 SHALL cover: all four requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle, rsp_id follows one cycle later; with the macro undefined -> grants always 0.
REQ-033 SHALL cover: rsp_ready=0 for 3 cycles with requests pending -> rsp outputs frozen, req_ready=0; rsp_ready rises -> held result drains and next grant issues in the same cycle.
REQ-034 SHALL cover: pointer at 3, only req 1 valid -> grant 1 (wrap), pointer becomes 2.
REQ-035 SHALL cover: rst asserted while rsp_valid=1 -> next cycle rsp_valid=0, rsp_data=0, rsp_id=0, pointer=0.
